clock_vip_clk_checker: RTL and testbench

- Receive-side counterpart of the clock VIP master driver.
- Oversamples `clock_in` with a faster free-running sample clock `clk`, then measures each period and high time in sample cycles.
- Checks measurements against the configured `period_ps`, `duty_cycle` and `jitter_ps`, and drives `clock_active` / `config_error` status plus per-period error pulses.
- Synthesizable; instantiated in the slave agent's bench top and bound to the slave/monitor view of the clock VIP interface.

---
 rtl/clock_vip_clk_checker.sv | 169 ++++++++++++++++
 tb/tb_clock_vip_clk_checker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_vip_clk_checker.sv
// Receive-side clock checker: oversamples clock_in with clk and measures period and high time.
// Each measured period is checked against the live period/duty/jitter config, with error pulses and a saturating count.
module clock_vip_clk_checker #(
  parameter int SAMPLE_PERIOD_PS = 1000,
  parameter int CNT_W            = 16,
  parameter int TIMEOUT_CYC      = 1000,
  parameter int DUTY_TOL_PCT     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clock_in,
  input  logic             enable,
  input  logic [31:0]      period_ps,
  input  logic [7:0]       duty_cycle,
  input  logic [31:0]      jitter_ps,
  output logic             clock_active,
  output logic             config_error,
  output logic             period_error,
  output logic             duty_error,
  output logic [CNT_W-1:0] meas_period_cyc,
  output logic [CNT_W-1:0] meas_high_cyc,
  output logic [15:0]      err_count
);

  typedef enum logic [1:0] {IDLE, WAIT_FIRST, MEASURE} state_t;

  localparam logic [63:0]      SPS    = 64'(SAMPLE_PERIOD_PS);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state, state_nxt;
  logic             sync_meta, sync, prev;
  logic             rise, fall;
  logic [CNT_W-1:0] period_cnt, period_cnt_nxt;
  logic [CNT_W-1:0] high_cnt, high_cnt_nxt;
  logic [CNT_W-1:0] meas_period_nxt, meas_high_nxt;
  logic             active_nxt, pe_nxt, de_nxt, cfg_bad;
  logic [15:0]      err_nxt;
  logic [16:0]      err_sum;

  // Check arithmetic, all in 64 bits so N*SPS*100 cannot overflow.
  logic [63:0] pps64, p_meas, p_diff, p_lim;
  logic [63:0] h_meas, h_exp, h_diff, h_lim;
  logic        per_bad, duty_bad;

  // Two-flop synchronizer plus previous-value register for edge detect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      prev      <= 1'b0;
    end else begin
      sync_meta <= clock_in;
      sync      <= sync_meta;
      prev      <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

  assign cfg_bad = enable & ((period_ps == 32'd0) | (duty_cycle == 8'd0) |
                             (duty_cycle > 8'd100) | (jitter_ps >= period_ps));

  // Period check uses the count being latched this cycle; duty uses the high time from the preceding fall.
  always_comb begin
    pps64    = 64'(period_ps);
    p_meas   = 64'(period_cnt) * SPS;
    p_diff   = (p_meas >= pps64) ? (p_meas - pps64) : (pps64 - p_meas);
    p_lim    = 64'(jitter_ps >> 1) + SPS;
    per_bad  = p_diff > p_lim;
    h_meas   = 64'(meas_high_cyc) * SPS * 64'd100;
    h_exp    = 64'(duty_cycle) * pps64;
    h_diff   = (h_meas >= h_exp) ? (h_meas - h_exp) : (h_exp - h_meas);
    h_lim    = 64'(DUTY_TOL_PCT) * pps64 + 64'd100 * SPS;
    duty_bad = h_diff > h_lim;
  end

  always_comb begin
    state_nxt       = state;
    period_cnt_nxt  = period_cnt;
    high_cnt_nxt    = high_cnt;
    meas_period_nxt = meas_period_cyc;
    meas_high_nxt   = meas_high_cyc;
    active_nxt      = clock_active;
    pe_nxt          = 1'b0;
    de_nxt          = 1'b0;
    if (!enable) begin
      state_nxt      = IDLE;
      active_nxt     = 1'b0;
      period_cnt_nxt = '0;
      high_cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          period_cnt_nxt = '0;
          high_cnt_nxt   = '0;
          active_nxt     = 1'b0;
          state_nxt      = WAIT_FIRST;
        end
        WAIT_FIRST: begin
          if (rise) begin
            period_cnt_nxt = ONE;
            high_cnt_nxt   = ONE;
            state_nxt      = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            meas_period_nxt = period_cnt;
            period_cnt_nxt  = ONE;
            high_cnt_nxt    = ONE;
            active_nxt      = 1'b1;
            pe_nxt          = per_bad;
            de_nxt          = duty_bad;
          end else begin
            if (fall) meas_high_nxt = high_cnt;
            if (sync) high_cnt_nxt = high_cnt + ONE;
            if (period_cnt >= TO_CNT) begin
              active_nxt = 1'b0;
              pe_nxt     = 1'b1;
              state_nxt  = WAIT_FIRST;
            end else begin
              period_cnt_nxt = period_cnt + ONE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    // An illegal config keeps measuring but must not report or count errors.
    if (config_error) begin
      pe_nxt = 1'b0;
      de_nxt = 1'b0;
    end
    err_sum = {1'b0, err_count} + 17'(pe_nxt) + 17'(de_nxt);
    err_nxt = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_cnt      <= '0;
      high_cnt        <= '0;
      meas_period_cyc <= '0;
      meas_high_cyc   <= '0;
      clock_active    <= 1'b0;
      config_error    <= 1'b0;
      period_error    <= 1'b0;
      duty_error      <= 1'b0;
      err_count       <= '0;
    end else begin
      period_cnt      <= period_cnt_nxt;
      high_cnt        <= high_cnt_nxt;
      meas_period_cyc <= meas_period_nxt;
      meas_high_cyc   <= meas_high_nxt;
      clock_active    <= active_nxt;
      config_error    <= cfg_bad;
      period_error    <= pe_nxt;
      duty_error      <= de_nxt;
      err_count       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_clock_vip_clk_checker.sv
// Bench for clock_vip_clk_checker: table of directed clock shapes, hand-written loss/reset/enable
// sequences, and random bursts scored against a per-period arithmetic model.
`timescale 1ns/1ps
module tb_clock_vip_clk_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clock_in = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] period_ps = '0;
  logic [7:0]  duty_cycle = '0;
  logic [31:0] jitter_ps = '0;
  logic        clock_active, config_error, period_error, duty_error;
  logic [15:0] meas_period_cyc, meas_high_cyc, err_count;

  always #5 clk = ~clk;

  clock_vip_clk_checker dut (
    .clk(clk), .rst_n(rst_n), .clock_in(clock_in), .enable(enable),
    .period_ps(period_ps), .duty_cycle(duty_cycle), .jitter_ps(jitter_ps),
    .clock_active(clock_active), .config_error(config_error),
    .period_error(period_error), .duty_error(duty_error),
    .meas_period_cyc(meas_period_cyc), .meas_high_cyc(meas_high_cyc),
    .err_count(err_count)
  );

  int total = 0;
  int bad = 0;
  int pe_seen = 0;
  int de_seen = 0;
  int exp_err = 0;

  always @(negedge clk) begin
    if (period_error) pe_seen++;
    if (duty_error)   de_seen++;
  end

  typedef struct {
    int h; int l; int pps; int duty; int jit; int n;
    int pe; int de; int mp; int mh; int cfg;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit cfg_bad(int pps, int duty, int jit);
    return pps == 0 || duty == 0 || duty > 100 || jit >= pps;
  endfunction

  function automatic bit per_bad(int n, int pps, int jit);
    longint d = longint'(n) * 1000 - pps;
    if (d < 0) d = -d;
    return d > longint'(jit / 2) + 1000;
  endfunction

  function automatic bit duty_bad(int h, int duty, int pps);
    longint d = longint'(h) * 100000 - longint'(duty) * pps;
    if (d < 0) d = -d;
    return d > 2 * longint'(pps) + 100000;
  endfunction

  function automatic int sat(int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic set_cfg(input int pps, input int duty, input int jit);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    period_ps  = 32'(pps);
    duty_cycle = 8'(duty);
    jitter_ps  = 32'(jit);
    clock_in   = 1'b0;
    enable     = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic drive_period(input int h, input int l);
    clock_in = 1'b1;
    repeat (h) @(negedge clk);
    clock_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  // Final rise closes the last driven period so it gets checked.
  task automatic tail();
    clock_in = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int pe0, de0, k;
    //         h  l  pps    duty jit    n  pe de mp mh cfg
    vecs[0]  = '{5, 5, 10000, 50,  0,     4, 0, 0, 10, 5, 0};
    vecs[1]  = '{5, 8, 10000, 50,  0,     4, 4, 0, 13, 5, 0};
    vecs[2]  = '{5, 8, 10000, 50,  8000,  4, 0, 0, 13, 5, 0};
    vecs[3]  = '{7, 3, 10000, 50,  0,     3, 0, 3, 10, 7, 0};
    vecs[4]  = '{7, 6, 10000, 150, 0,     3, 0, 0, 13, 7, 1};
    vecs[5]  = '{5, 8, 10000, 50,  10000, 3, 0, 0, 13, 5, 1};
    vecs[6]  = '{6, 6, 10000, 60,  2000,  2, 0, 0, 12, 6, 0};
    vecs[7]  = '{6, 7, 10000, 60,  2000,  2, 2, 0, 13, 6, 0};
    vecs[8]  = '{5, 5, 10000, 38,  0,     2, 0, 0, 10, 5, 0};
    vecs[9]  = '{5, 5, 10000, 37,  0,     2, 0, 2, 10, 5, 0};
    vecs[10] = '{4, 5, 10000, 40,  0,     2, 0, 0, 9,  4, 0};
    vecs[11] = '{4, 4, 10000, 40,  0,     2, 2, 0, 8,  4, 0};

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_active", clock_active, 0);
    chk("rst_cfgerr", config_error, 0);
    chk("rst_pulses", {period_error, duty_error}, 0);
    chk("rst_meas", {meas_period_cyc, meas_high_cyc}, 0);
    chk("rst_errcnt", err_count, 0);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      set_cfg(vecs[i].pps, vecs[i].duty, vecs[i].jit);
      pe0 = pe_seen;
      de0 = de_seen;
      for (int j = 0; j < vecs[i].n; j++) drive_period(vecs[i].h, vecs[i].l);
      tail();
      chk($sformatf("v%0d_cfgerr", i), config_error, vecs[i].cfg);
      chk($sformatf("v%0d_pe", i), pe_seen - pe0, vecs[i].pe);
      chk($sformatf("v%0d_de", i), de_seen - de0, vecs[i].de);
      chk($sformatf("v%0d_mp", i), meas_period_cyc, vecs[i].mp);
      chk($sformatf("v%0d_mh", i), meas_high_cyc, vecs[i].mh);
      chk($sformatf("v%0d_active", i), clock_active, 1);
      exp_err = sat(exp_err + vecs[i].pe + vecs[i].de);
      chk($sformatf("v%0d_errcnt", i), err_count, exp_err);
    end

    // Clock loss: counter resets 3 cycles after the driven rise, timeout 1000 cycles later
    set_cfg(10000, 50, 0);
    drive_period(5, 5);
    drive_period(5, 5);
    pe0 = pe_seen;
    clock_in = 1'b1;
    k = 0;
    while (k < 2000) begin
      @(negedge clk);
      k++;
      if (k == 5) clock_in = 1'b0;
      if (!clock_active) break;
    end
    chk("loss_latency", k, 1003);
    repeat (3) @(negedge clk);
    chk("loss_pe", pe_seen - pe0, 1);
    exp_err = sat(exp_err + 1);
    chk("loss_errcnt", err_count, exp_err);
    chk("loss_mp_held", meas_period_cyc, 10);
    drive_period(5, 5);
    chk("restart_first_rise", clock_active, 0);
    tail();
    chk("restart_second_rise", clock_active, 1);

    // Enable deassert mid-period
    drive_period(5, 3);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_active", clock_active, 0);
    chk("dis_cfgerr", config_error, 0);
    chk("dis_errcnt_held", err_count, exp_err);
    chk("dis_mp_held", meas_period_cyc, 10);

    // Random bursts against the model
    for (int b = 0; b < 40; b++) begin
      int pps, duty, jit, n, h, l, epe, ede, lh, ll;
      pps  = $urandom_range(4000, 30000);
      duty = $urandom_range(0, 110);
      jit  = ($urandom_range(0, 9) == 0) ? pps : $urandom_range(0, 8000);
      n    = $urandom_range(1, 4);
      epe = 0; ede = 0; lh = 0; ll = 0;
      set_cfg(pps, duty, jit);
      pe0 = pe_seen;
      de0 = de_seen;
      for (int j = 0; j < n; j++) begin
        h = $urandom_range(2, 14);
        l = $urandom_range(2, 14);
        drive_period(h, l);
        if (!cfg_bad(pps, duty, jit)) begin
          epe += per_bad(h + l, pps, jit);
          ede += duty_bad(h, duty, pps);
        end
        lh = h; ll = l;
      end
      tail();
      chk($sformatf("r%0d_cfgerr", b), config_error, cfg_bad(pps, duty, jit));
      chk($sformatf("r%0d_pe", b), pe_seen - pe0, epe);
      chk($sformatf("r%0d_de", b), de_seen - de0, ede);
      chk($sformatf("r%0d_mp", b), meas_period_cyc, lh + ll);
      chk($sformatf("r%0d_mh", b), meas_high_cyc, lh);
      exp_err = sat(exp_err + epe + ede);
      chk($sformatf("r%0d_errcnt", b), err_count, exp_err);
    end

    // Reset mid-measurement clears everything
    set_cfg(10000, 50, 0);
    drive_period(5, 5);
    clock_in = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_active", clock_active, 0);
    chk("midrst_meas", {meas_period_cyc, meas_high_cyc}, 0);
    chk("midrst_errcnt", err_count, 0);
    chk("midrst_flags", {config_error, period_error, duty_error}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
